// File: rtl/fp32_max_min_reduce.sv
// Streaming FP32 max/min reduction: folds one packet of operands into a single
// extreme value, with element count and NaN flag, returned over valid/ready.
module fp32_max_min_reduce #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_data,
    input  logic             i_last,
    input  logic             i_is_max,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [31:0]      o_res,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_nan_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              nan_q, nan_d;
    logic              mode_q, mode_d;
    logic              ready_q, ready_d;
    logic              res_valid_q, res_valid_d;
    logic              beat;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Total order: positive beats negative (so +0 > -0); same sign compares
    // magnitudes, reversed when both are negative.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return ~a[31];
        else if (!a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    // Replace the accumulator only on a strict improvement; ties keep acc.
    function automatic logic [31:0] sel_op(input logic [31:0] acc,
                                           input logic [31:0] x,
                                           input logic        is_max);
        if (is_max)
            return fp_gt(x, acc) ? x : acc;
        else
            return fp_gt(acc, x) ? x : acc;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign beat = i_valid && ready_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nan_d   = nan_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d   = i_data;
                    mode_d  = i_is_max;
                    cnt_d   = CNT_W'(1);
                    nan_d   = is_nan(i_data);
                    state_d = i_last ? OUT : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_d = sel_op(acc_q, i_data, mode_q);
                    cnt_d = sat_inc(cnt_q);
                    nan_d = nan_q | is_nan(i_data);
                    if (i_last)
                        state_d = OUT;
                end
            end
            OUT: begin
                if (i_res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d != OUT);
        res_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 32'd0;
            cnt_q       <= '0;
            nan_q       <= 1'b0;
            mode_q      <= 1'b0;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            nan_q       <= nan_d;
            mode_q      <= mode_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_res_valid = res_valid_q;
    assign o_res       = nan_q ? QNAN : acc_q;
    assign o_cnt       = cnt_q;
    assign o_nan_err   = nan_q;

endmodule
